// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, debounce FSM states and the
// hundreds-digit limit used by both the entry block and the display path.
package calc_pkg;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_BS  = 4'hB;

    // Largest value the hundreds digit may hold (operands stop at 399).
    localparam logic [1:0] MAX_HUN = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } deb_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key strobe synchronizer and debouncer. Emits one accept pulse per press,
// together with the key code sampled from the synchronized bus at that moment.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no key; waiting for the synchronized strobe to rise
// PRESS_DEB | key seen high; counting consecutive high samples
// HELD      | press accepted; waiting for the key to drop (no repeat)
// REL_DEB   | key seen low; counting consecutive low samples
module key_debounce
    import calc_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_down_i,
    input  logic [3:0] key_code_i,
    output logic       accept_o,
    output logic [3:0] code_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          key_s1_q, key_s2_q;
    logic [3:0]    code_s1_q, code_s2_q;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept_q, accept_d;
    logic [3:0]    code_q, code_d;

    // Two-flop synchronizer for the asynchronous keypad strobe and code bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q  <= 1'b0;
            key_s2_q  <= 1'b0;
            code_s1_q <= 4'd0;
            code_s2_q <= 4'd0;
        end else begin
            key_s1_q  <= key_down_i;
            key_s2_q  <= key_s1_q;
            code_s1_q <= key_code_i;
            code_s2_q <= code_s1_q;
        end
    end

    // FSM state, debounce counter and registered accept/code outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            code_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            code_q   <= code_d;
        end
    end

    // Next-state logic; the entry sample of each debounce phase counts as the first.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s2_q) begin
                    state_d = PRESS_DEB;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_DEB: begin
                if (!key_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HELD;
                    cnt_d    = '0;
                    accept_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!key_s2_q) begin
                    state_d = REL_DEB;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_DEB: begin
                if (key_s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        code_d = accept_d ? code_s2_q : code_q;
    end

    assign accept_o = accept_q;
    assign code_o   = code_q;

endmodule

// File: rtl/key_entry.sv
// Operand entry: shifts debounced keypad digits into a three-digit BCD
// operand (0..399) with clear and backspace editing.
// Optional feature macro: KEY_ENTRY_BACKSPACE_EN (code 4'hB edits as backspace;
// without it 4'hB is rejected like any other invalid code).
module key_entry
    import calc_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_down_i,
    input  logic [3:0] key_code_i,
    input  logic       entry_clr_i,
    output logic [1:0] hun_o,
    output logic [3:0] ten_o,
    output logic [3:0] one_o,
    output logic [1:0] ndig_o,
    output logic       key_ack_o,
    output logic       key_err_o
);

    logic       accept;
    logic [3:0] code;

    logic [1:0] hun_q, hun_d;
    logic [3:0] ten_q, ten_d;
    logic [3:0] one_q, one_d;
    logic [1:0] ndig_q, ndig_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_down_i (key_down_i),
        .key_code_i (key_code_i),
        .accept_o   (accept),
        .code_o     (code)
    );

    // Operand digit and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hun_q  <= 2'd0;
            ten_q  <= 4'd0;
            one_q  <= 4'd0;
            ndig_q <= 2'd0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hun_q  <= hun_d;
            ten_q  <= ten_d;
            one_q  <= one_d;
            ndig_q <= ndig_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    // Edit decode; a controller clear wins over, and silently drops, a key.
    always_comb begin
        hun_d  = hun_q;
        ten_d  = ten_q;
        one_d  = one_q;
        ndig_d = ndig_q;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        if (entry_clr_i) begin
            hun_d  = 2'd0;
            ten_d  = 4'd0;
            one_d  = 4'd0;
            ndig_d = 2'd0;
        end else if (accept) begin
            if (is_digit(code)) begin
                case (ndig_q)
                    2'd0: begin
                        one_d  = code;
                        ndig_d = (code != 4'd0) ? 2'd1 : 2'd0;
                        ack_d  = 1'b1;
                    end
                    2'd1: begin
                        ten_d  = one_q;
                        one_d  = code;
                        ndig_d = 2'd2;
                        ack_d  = 1'b1;
                    end
                    2'd2: begin
                        // The tens digit becomes hundreds; above 3 it would pass 399.
                        if (ten_q <= {2'b00, MAX_HUN}) begin
                            hun_d  = ten_q[1:0];
                            ten_d  = one_q;
                            one_d  = code;
                            ndig_d = 2'd3;
                            ack_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end else begin
                case (code)
                    KEY_CLR: begin
                        hun_d  = 2'd0;
                        ten_d  = 4'd0;
                        one_d  = 4'd0;
                        ndig_d = 2'd0;
                        ack_d  = 1'b1;
                    end
`ifdef KEY_ENTRY_BACKSPACE_EN
                    KEY_BS: begin
                        if (ndig_q != 2'd0) begin
                            one_d  = ten_q;
                            ten_d  = {2'b00, hun_q};
                            hun_d  = 2'd0;
                            ndig_d = ndig_q - 2'd1;
                        end
                        ack_d = 1'b1;
                    end
`endif
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    assign hun_o     = hun_q;
    assign ten_o     = ten_q;
    assign one_o     = one_q;
    assign ndig_o    = ndig_q;
    assign key_ack_o = ack_q;
    assign key_err_o = err_q;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: directed scenarios plus random key
// presses, checked against an arithmetic model of the operand value.
module tb_key_entry;

    localparam int DEB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_down;
    logic [3:0] key_code;
    logic       entry_clr;
    logic [1:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
    logic [1:0] ndig;
    logic       key_ack;
    logic       key_err;

    key_entry #(.DEB_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_down_i  (key_down),
        .key_code_i  (key_code),
        .entry_clr_i (entry_clr),
        .hun_o       (hun),
        .ten_o       (ten),
        .one_o       (one),
        .ndig_o      (ndig),
        .key_ack_o   (key_ack),
        .key_err_o   (key_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: operand as an integer value plus count of significant digits.
    int m_val  = 0;
    int m_ndig = 0;

    int mon_ack, mon_err, mon_both, mon_first, mon_cyc;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_digits(input string tag);
        check({tag, ".hun"},  int'(hun),  m_val / 100);
        check({tag, ".ten"},  int'(ten),  (m_val / 10) % 10);
        check({tag, ".one"},  int'(one),  m_val % 10);
        check({tag, ".ndig"}, int'(ndig), m_ndig);
    endtask

    // Apply one accepted key to the model; returns the expected ack/err pulses.
    task automatic model_key(input int code, output int e_ack, output int e_err);
        int nv;
        e_ack = 0;
        e_err = 0;
        if (code <= 9) begin
            if (m_ndig == 0) begin
                m_val  = code;
                m_ndig = (code != 0) ? 1 : 0;
                e_ack  = 1;
            end else if (m_ndig == 1) begin
                m_val  = m_val * 10 + code;
                m_ndig = 2;
                e_ack  = 1;
            end else if (m_ndig == 2) begin
                nv = m_val * 10 + code;
                if (nv > 399) e_err = 1;
                else begin
                    m_val  = nv;
                    m_ndig = 3;
                    e_ack  = 1;
                end
            end else begin
                e_err = 1;
            end
        end else if (code == 10) begin
            m_val  = 0;
            m_ndig = 0;
            e_ack  = 1;
`ifdef KEY_ENTRY_BACKSPACE_EN
        end else if (code == 11) begin
            if (m_ndig > 0) begin
                m_val  = m_val / 10;
                m_ndig = m_ndig - 1;
            end
            e_ack = 1;
`endif
        end else begin
            e_err = 1;
        end
    endtask

    task automatic mon_clear();
        mon_ack   = 0;
        mon_err   = 0;
        mon_both  = 0;
        mon_first = -1;
        mon_cyc   = 0;
    endtask

    // One clock: sample outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        mon_cyc++;
        if (key_ack) begin
            mon_ack++;
            if (mon_first < 0) mon_first = mon_cyc;
        end
        if (key_err) mon_err++;
        if (key_ack && key_err) mon_both++;
    endtask

    task automatic raw_press(input int code, input int hold, input int rel);
        @(negedge clk);
        key_code = 4'(code);
        key_down = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        @(negedge clk);
        key_down = 1'b0;
        for (int i = 0; i < rel; i++) tick();
    endtask

    task automatic press(input string tag, input int code, input int hold, input int rel);
        int e_ack, e_err;
        mon_clear();
        raw_press(code, hold, rel);
        model_key(code, e_ack, e_err);
        check({tag, ".ack"},  mon_ack,  e_ack);
        check({tag, ".err"},  mon_err,  e_err);
        check({tag, ".both"}, mon_both, 0);
        check_digits(tag);
    endtask

    task automatic clean(input string tag, input int code);
        press(tag, code, DEB + 4, 2 * DEB + 4);
    endtask

    initial begin
        int e_ack, e_err, hold, code;
        rst_n     = 1'b0;
        key_down  = 1'b0;
        key_code  = 4'd0;
        entry_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ack", int'(key_ack), 0);
        check("reset.err", int'(key_err), 0);
        check_digits("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean 1,2,3 with first-ack latency from the raw edge.
        mon_clear();
        raw_press(1, DEB + 4, 2 * DEB + 4);
        model_key(1, e_ack, e_err);
        check("lat.first_ack", mon_first, DEB + 3);
        check("lat.ack", mon_ack, 1);
        clean("p2", 2);
        clean("p3", 3);
        check("p123.hun", int'(hun), 1);
        check("p123.ten", int'(ten), 2);
        check("p123.one", int'(one), 3);
        clean("p4th", 4);
        check("p4th.err_seen", mon_err, 1);

        // 4,5,6 overflows past 399.
        clean("clr1", 10);
        clean("d4", 4);
        clean("d5", 5);
        clean("d6", 6);
        check("d456.err_seen", mon_err, 1);
        check("d456.ten", int'(ten), 4);
        check("d456.one", int'(one), 5);

        // Leading zeros.
        clean("clr2", 10);
        clean("z0a", 0);
        clean("z0b", 0);
        clean("z7", 7);
        check("z007.ndig", int'(ndig), 1);

        // Bouncy press and a release glitch give a single ack.
        clean("clr3", 10);
        mon_clear();
        key_code = 4'd5;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key_down = ((i / 3) % 2) == 0;
            tick();
        end
        @(negedge clk);
        key_down = 1'b1;
        for (int i = 0; i < DEB + 4; i++) tick();
        @(negedge clk);
        key_down = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        key_down = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        @(negedge clk);
        key_down = 1'b0;
        for (int i = 0; i < 2 * DEB + 4; i++) tick();
        model_key(5, e_ack, e_err);
        check("bounce.ack", mon_ack, 1);
        check("bounce.err", mon_err, 0);
        check_digits("bounce");

        // 2,5,9 then backspace, then clear.
        clean("clr4", 10);
        clean("b2", 2);
        clean("b5", 5);
        clean("b9", 9);
        clean("bs", 11);
        clean("bsclr", 10);

        // entry_clr coincident with acceptance of digit 8.
        clean("e3", 3);
        mon_clear();
        @(negedge clk);
        key_code = 4'd8;
        key_down = 1'b1;
        for (int i = 0; i < DEB + 2; i++) tick();
        @(negedge clk);
        entry_clr = 1'b1;
        tick();
        @(negedge clk);
        entry_clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        key_down = 1'b0;
        for (int i = 0; i < 2 * DEB + 4; i++) tick();
        m_val  = 0;
        m_ndig = 0;
        check("eclr.ack", mon_ack, 0);
        check("eclr.err", mon_err, 0);
        check_digits("eclr");

        // Reset in the middle of press debounce.
        clean("r4", 4);
        clean("r2", 2);
        mon_clear();
        @(negedge clk);
        key_code = 4'd6;
        key_down = 1'b1;
        for (int i = 0; i < DEB / 2; i++) tick();
        @(negedge clk);
        rst_n    = 1'b0;
        key_down = 1'b0;
        m_val    = 0;
        m_ndig   = 0;
        tick();
        check_digits("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * DEB + 4; i++) tick();
        check("rst_mid.ack", mon_ack, 0);
        check("rst_mid.err", mon_err, 0);
        check_digits("rst_after");

        // Random key presses.
        for (int n = 0; n < 40; n++) begin
            code = int'($urandom_range(0, 15));
            if (code > 11 && ($urandom_range(0, 1) == 0)) code = int'($urandom_range(0, 9));
            hold = DEB + 1 + int'($urandom_range(0, 5));
            press($sformatf("rnd%0d", n), code, hold, 2 * DEB + 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/key_entry.md
# key_entry

Operand entry block for the calculator: turns raw keypad presses into the three BCD operand digits `hun`/`ten`/`one` that feed the seven-segment display path. It synchronizes and debounces the key strobe, accepts one key per press, and shifts digits in from the right with clear and backspace editing. It sits between the board keypad and the operand register/display, and is the input-side counterpart of the BCD-to-segment display driver.

## Interface
- `DEB_CYCLES`, 16: consecutive stable synchronized samples required to accept a press or a release (≥2).
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_down` in 1: raw key-pressed level from the keypad; asynchronous and bouncy.
- `key_code` in 4: raw key code, stable while `key_down` is high. 0–9 digits, 4'hA clear, 4'hB backspace, 4'hC–4'hF invalid.
- `entry_clr` in 1: synchronous one-cycle clear from the calculator controller.
- `hun` out 2: hundreds digit, 0–3.
- `ten` out 4: tens digit, 0–9.
- `one` out 4: ones digit, 0–9.
- `ndig` out 2: count of significant digits entered, 0–3.
- `key_ack` out 1: one-cycle pulse when a key is accepted and applied.
- `key_err` out 1: one-cycle pulse when an accepted key is rejected.

## Operation
- Reset: `hun`=0, `ten`=0, `one`=0, `ndig`=0, `key_ack`=0, `key_err`=0; FSM in IDLE; synchronizer and debounce counter cleared.
- `key_down` and `key_code` pass through a 2-flop synchronizer. `key_code` is captured from the synchronized copy at the moment of acceptance.
- FSM states and transitions:
  - IDLE → PRESS_DEB when the synchronized key is high.
  - PRESS_DEB: the counter increments while the key stays high. A low sample returns the FSM to IDLE and clears the counter. When the count reaches `DEB_CYCLES`, the key is accepted and the FSM goes to HELD.
  - HELD → REL_DEB when the key goes low.
  - REL_DEB: a high sample returns the FSM to HELD. `DEB_CYCLES` consecutive low samples return it to IDLE.
- Only one acceptance per press; there is no auto-repeat.
- Digit key `d`, by `ndig`:
  - 0: `one`=d. `ndig` becomes 1 if d≠0; if d=0 it stays 0 (leading zero). Ack.
  - 1: `ten`=`one`, `one`=d, `ndig`=2. Ack.
  - 2: if `ten`≤3, then `hun`=`ten[1:0]`, `ten`=`one`, `one`=d, `ndig`=3, ack. If `ten`>3, no change and err (value would exceed 399).
  - 3: no change, err.
- Clear (4'hA): all digits and `ndig` go to 0. Ack.
- Backspace (4'hB): `one`=`ten`, `ten`=`hun`, `hun`=0, `ndig`=`ndig`−1. At `ndig`=0: no change, ack.
- Codes 4'hC–4'hF: no change, err.
- `entry_clr`: zeroes the digits and `ndig` and has priority. A key accepted in the same cycle is discarded with no ack and no err. The FSM still proceeds to HELD.
- `key_ack` and `key_err` are never high together.

## Timing
- Latency: if synchronized `key_down` is first high at cycle N, acceptance occurs at cycle N+`DEB_CYCLES`. Digit outputs and the ack/err pulse are registered and appear at N+`DEB_CYCLES`+1. From the raw input edge, add 2 cycles of synchronizer delay.
- Every output is a flop; there are no combinational paths from inputs to outputs.
- A bounce inside PRESS_DEB restarts the full debounce count.
- Minimum press-to-press spacing is 2×`DEB_CYCLES` plus synchronizer delay.
- Reset asserted mid-debounce or mid-HELD aborts the press with no ack. A key still held when reset releases is treated as a new press.
- `entry_clr` takes effect on the next clock edge: outputs are 0 one cycle after it is sampled.

## Configuration
- `KEY_ENTRY_BACKSPACE_EN` defined: code 4'hB behaves as backspace, as described above.
- `KEY_ENTRY_BACKSPACE_EN` undefined: 4'hB is treated as an invalid code (no change, `key_err` pulse). The shift-right datapath is not built.

## Structure
- Shared package `calc_pkg` holds:
  - key code constants `KEY_CLR`=4'hA and `KEY_BS`=4'hB;
  - the FSM state typedef (IDLE, PRESS_DEB, HELD, REL_DEB);
  - the `MAX_HUN`=3 constant shared with the display path.
- One sub-module, `key_debounce`: the synchronizer, FSM and counter. It outputs a one-cycle `accept` pulse plus the captured code.
- The top level `key_entry` contains the digit shift/edit datapath.

## Test plan
- Clean presses 1, 2, 3 (hold `DEB_CYCLES`+4, release same) → `hun`=1, `ten`=2, `one`=3, `ndig`=3, three `key_ack` pulses, first ack at exactly N+`DEB_CYCLES`+1.
- Enter 4, 5, then 6 → third key gives `key_err`; digits stay `ten`=4, `one`=5, `ndig`=2. A fourth digit after 1, 2, 3 also gives err.
- Press 0, 0, 7 → `one`=7, `ndig`=1; the leading zeros are acked but not counted.
- Bounce: toggle `key_down` every 3 cycles for 20 cycles, then hold steady high → exactly one ack; a glitch during the release also gives no extra ack.
- Enter 2, 5, 9, then backspace → `ten`=2, `one`=5, `ndig`=2. Then clear (4'hA) → all 0. With the macro undefined, backspace gives err and no change.
- Assert `entry_clr` in the acceptance cycle of digit 8 → outputs 0, no ack/err. Assert `rst_n` low mid-PRESS_DEB → all outputs 0 and no ack for that press.
